// File: rtl/ps2_zx_keyboard.sv
// PS/2 set-2 keyboard receiver and ZX Spectrum 8x5 key matrix.
// Answers ULA port #FE row selects on a_hi with active-low kd.
`timescale 1ns/1ps
module ps2_zx_keyboard #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2800
) (
  input  logic       clk14,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic [7:0] a_hi,
  output logic [4:0] kd,
  output logic       rst_req
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   s_clk;
  logic                   s_dat;

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
    end
  end

  assign s_clk = clk_sync[SYNC_STAGES-1];
  assign s_dat = dat_sync[SYNC_STAGES-1];

  logic          filt;
  logic          strobe;
  logic [FW-1:0] fcnt;

  // a new level is taken only after FILTER_LEN equal samples
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      filt   <= 1'b1;
      fcnt   <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (s_clk == filt) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt   <= s_clk;
        fcnt   <= '0;
        strobe <= ~s_clk;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  rx_state_t     state;
  logic [7:0]    shreg;
  logic [2:0]    bcnt;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          byte_valid;

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bcnt       <= '0;
      par        <= 1'b0;
      tcnt       <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (strobe) begin
        tcnt <= '0;
        unique case (state)
          IDLE: begin
            if (!s_dat) begin
              state <= DATA;
              bcnt  <= '0;
            end
          end
          DATA: begin
            shreg <= {s_dat, shreg[7:1]};
            bcnt  <= bcnt + 1'b1;
            if (bcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= s_dat;
            state <= STOP;
          end
          STOP: begin
            byte_valid <= s_dat & (^{par, shreg});
            state      <= IDLE;
          end
        endcase
      end else if (state != IDLE) begin
        if (tcnt == TW'(TIMEOUT_CYCLES)) begin
          state <= IDLE;
          tcnt  <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

  // result is {hit, row, col}
  function automatic logic [6:0] key_map(
    input logic       e,
    input logic [7:0] code
  );
    logic [6:0] m;
    m = '0;
    if (e) begin
      case (code)
        8'h5A:   m = 7'o160;
        8'h14:   m = 7'o171;
        default: m = '0;
      endcase
    end else begin
      case (code)
        8'h12, 8'h59: m = 7'o100;
        8'h1A: m = 7'o101;
        8'h22: m = 7'o102;
        8'h21: m = 7'o103;
        8'h2A: m = 7'o104;
        8'h1C: m = 7'o110;
        8'h1B: m = 7'o111;
        8'h23: m = 7'o112;
        8'h2B: m = 7'o113;
        8'h34: m = 7'o114;
        8'h15: m = 7'o120;
        8'h1D: m = 7'o121;
        8'h24: m = 7'o122;
        8'h2D: m = 7'o123;
        8'h2C: m = 7'o124;
        8'h16: m = 7'o130;
        8'h1E: m = 7'o131;
        8'h26: m = 7'o132;
        8'h25: m = 7'o133;
        8'h2E: m = 7'o134;
        8'h45: m = 7'o140;
        8'h46: m = 7'o141;
        8'h3E: m = 7'o142;
        8'h3D: m = 7'o143;
        8'h36: m = 7'o144;
        8'h4D: m = 7'o150;
        8'h44: m = 7'o151;
        8'h43: m = 7'o152;
        8'h3C: m = 7'o153;
        8'h35: m = 7'o154;
        8'h5A: m = 7'o160;
        8'h4B: m = 7'o161;
        8'h42: m = 7'o162;
        8'h3B: m = 7'o163;
        8'h33: m = 7'o164;
        8'h29: m = 7'o170;
        8'h14: m = 7'o171;
        8'h3A: m = 7'o172;
        8'h31: m = 7'o173;
        8'h32: m = 7'o174;
        default: m = '0;
      endcase
    end
    return m;
  endfunction

  logic [7:0][4:0] pressed;
  logic            ext;
  logic            brk;
  logic [2:0]      skip;
  logic [6:0]      km;

  always_comb km = key_map(ext, shreg);

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      pressed <= '0;
      ext     <= 1'b0;
      brk     <= 1'b0;
      skip    <= '0;
      rst_req <= 1'b0;
    end else if (byte_valid) begin
      if (skip != 3'd0) begin
        skip <= skip - 3'd1;
      end else begin
        unique case (1'b1)
          shreg == 8'hE0: ext <= 1'b1;
          shreg == 8'hF0: brk <= 1'b1;
          shreg == 8'hE1: skip <= 3'd7;
          shreg == 8'hAA || shreg == 8'h00 ||
          shreg == 8'hFF: pressed <= '0;
          shreg == 8'hFA || shreg == 8'hFE ||
          shreg == 8'hEE: ;
          default: begin
            if (km[6]) pressed[km[5:3]][km[2:0]] <= ~brk;
            if (shreg == 8'h07 && !ext) rst_req <= ~brk;
            ext <= 1'b0;
            brk <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    logic [4:0] col;
    col = '0;
    for (int r = 0; r < 8; r++) begin
      if (!a_hi[r]) col = col | pressed[r];
    end
    kd = ~col;
  end

endmodule
